// File: rtl/seg_pkg.sv
// seg_pkg: shared segment width, hex-to-segment table and scan state type.
package seg_pkg;
  localparam int SEG_W = 7;
  // Entry n occupies bits [7n+6:7n]; segments are {g,f,e,d,c,b,a}.
  localparam logic [16*SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {BLANK, SHOW} scan_state_e;
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-high 7-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_o
);
  assign seg_o = SEG_TABLE[nib_i*SEG_W +: SEG_W];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with frame-aligned double-buffered updates.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  output logic                  upd_pending,
  output logic [SEG_W-1:0]      seg_out,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_tick
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(DIGITS);
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  scan_state_e         state_q, state_d;
  logic [4*DIGITS-1:0] active_q, active_d, shadow_q, shadow_d;
  logic                pend_q, pend_d, tick_q, tick_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [SEG_W-1:0]    seg_q, seg_d, dec;
  logic [3:0]          nib;
  logic                wrap_dw, wrap_fr, lz;
  seg_hex_decode u_dec (.nib_i(nib), .seg_o(dec));
  // Outputs are computed from next-cycle counters so sel and seg_out register together.
  always_comb begin
    wrap_dw  = cnt_q == CW'(DIV - 1);
    wrap_fr  = wrap_dw && idx_q == IW'(DIGITS - 1);
    cnt_d    = wrap_dw ? '0 : cnt_q + 1'b1;
    idx_d    = wrap_dw ? (wrap_fr ? '0 : idx_q + 1'b1) : idx_q;
    state_d  = cnt_d < CW'(BLANK_CYC) ? BLANK : SHOW;
    shadow_d = load ? data_in : shadow_q;
    pend_d   = load ? !wrap_fr : (wrap_fr ? 1'b0 : pend_q);
    active_d = wrap_fr ? (load ? data_in : (pend_q ? shadow_q : active_q)) : active_q;
    nib      = active_d[idx_d*4 +: 4];
    sel_d    = state_d == SHOW ? DIGITS'(1) << idx_d : '0;
    seg_d    = state_d == SHOW && !lz ? dec : '0;
    tick_d   = wrap_fr;
  end
`ifdef SEG_LZB_EN
  assign lz = idx_d != '0 && (active_d >> (idx_d*4)) == '0;
`else
  assign lz = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= BLANK;
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      sel_q    <= '0;
      seg_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      tick_q   <= tick_d;
    end
  end
  assign upd_pending = pend_q;
  assign seg_out     = seg_q;
  assign sel         = sel_q;
  assign frame_tick  = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus random stimulus against a frame/dwell arithmetic model.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4, DIV = 4, BLANK = 1, FRAME = DIGITS * DIV;
  localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 0, rst = 0, load = 0;
  logic [15:0] data_in = '0;
  logic upd_pending, frame_tick;
  logic [6:0] seg_out;
  logic [3:0] sel;
  int n_cmp = 0, n_bad = 0;
  int t = 0;
  logic [15:0] m_shadow = '0, m_active = '0;
  bit m_pend = 0;
  seg_scan_ctrl #(.DIGITS(4), .CLK_HZ(8), .SCAN_HZ(2), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .upd_pending(upd_pending),
    .seg_out(seg_out), .sel(sel), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask
  task automatic check_outputs();
    int ph, idx;
    logic [3:0] e_sel;
    logic [6:0] e_seg;
    ph    = t % DIV;
    idx   = (t / DIV) % DIGITS;
    e_sel = ph < BLANK ? 4'b0 : 4'(1 << idx);
    e_seg = ph < BLANK ? 7'h0 : TBL[m_active[idx*4 +: 4]];
`ifdef SEG_LZB_EN
    if (idx > 0 && (m_active >> (4*idx)) == 16'h0) e_seg = 7'h0;
`endif
    chk("sel", 32'(sel), 32'(e_sel));
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("frame_tick", 32'(frame_tick), 32'(t > 0 && t % FRAME == 0));
    chk("upd_pending", 32'(upd_pending), 32'(m_pend));
  endtask
  task automatic step(bit r, bit l, logic [15:0] d);
    @(negedge clk);
    rst = r; load = l; data_in = d;
    @(posedge clk);
    if (!r) begin
      t = 0; m_shadow = '0; m_active = '0; m_pend = 0;
    end else begin
      t++;
      if (t % FRAME == 0) begin
        if (l) m_active = d;
        else if (m_pend) m_active = m_shadow;
        m_pend = 0;
      end else if (l) begin
        m_shadow = d; m_pend = 1;
      end
    end
    #1 check_outputs();
  endtask
  task automatic run(int n, int at1, logic [15:0] d1, int at2, logic [15:0] d2);
    for (int i = 0; i < n; i++) begin
      if (t == at1) step(1, 1, d1);
      else if (t == at2) step(1, 1, d2);
      else step(1, 0, 16'h0);
    end
  endtask
  initial begin
    step(0, 0, 16'h0);
    step(0, 0, 16'h0);
    run(32, -1, 0, -1, 0);
    step(0, 0, 16'h0);
    run(32, 5, 16'h1234, -1, 0);
    step(0, 0, 16'h0);
    run(32, 3, 16'h1234, 9, 16'hABCD);
    step(0, 0, 16'h0);
    run(32, 15, 16'h00FF, -1, 0);
    step(0, 0, 16'h0);
    run(48, 2, 16'h0050, 20, 16'h0000);
    run(24, 40, 16'hBEEF, -1, 0);
    step(0, 0, 16'h0);
    run(40, -1, 0, -1, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0, d);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
